// File: rtl/curve25519_pkg.sv
// Shared types and constants for the curve25519 core arbiter and its helpers.
// Holds field width, FSM encoding, requester IDs and scalar clamp masks.
package curve25519_pkg;

  localparam int FIELD_W = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SETTLE,
    ST_RUN,
    ST_RESP
  } arb_state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  // X25519 clamping: clear the cofactor bits, force the top bit of the field
  localparam logic [FIELD_W-1:0] CLAMP_CLR_MASK = {{(FIELD_W-3){1'b1}}, 3'b000};
  localparam logic [FIELD_W-1:0] CLAMP_SET_MASK = {1'b1, {(FIELD_W-1){1'b0}}};

  function automatic logic [FIELD_W-1:0] clamp_scalar(input logic [FIELD_W-1:0] n);
    return (n & CLAMP_CLR_MASK) | CLAMP_SET_MASK;
  endfunction

endpackage

// File: rtl/curve25519_rr_pick.sv
// Two-way round-robin pick: one-hot grant (bit 0 = A, bit 1 = B) plus any-valid flag.
// Purely combinational so it can be reused by wider schedulers.
module curve25519_rr_pick
  import curve25519_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       any
);

  // On a tie the requester that was not served last wins
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (last_grant == ID_B) ? 2'b01 : 2'b10;
    end
  end

  assign any = |valid;

endmodule

// File: rtl/curve25519_arbiter.sv
// Round-robin arbiter sharing one curve25519 scalar-multiply core between requesters A and B.
// Define CURVE25519_ARB_CLAMP_EN to clamp the latched scalar before it reaches the core.
module curve25519_arbiter
  import curve25519_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [FIELD_W-1:0] a_n,
  input  logic [FIELD_W-1:0] a_q,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [FIELD_W-1:0] b_n,
  input  logic [FIELD_W-1:0] b_q,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic               rsp_timeout,
  output logic [FIELD_W-1:0] rsp_out,
  output logic               core_start,
  output logic [FIELD_W-1:0] core_n,
  output logic [FIELD_W-1:0] core_q,
  input  logic               core_done,
  input  logic [FIELD_W-1:0] core_out
);

  arb_state_t           state;
  arb_state_t           state_next;
  logic                 last_grant;
  logic [TIMEOUT_W-1:0] watchdog;
  logic                 wd_expired;
  logic [1:0]           pick_grant;
  logic                 pick_any;
  logic                 grant_en;
  logic [FIELD_W-1:0]   sel_n;
  logic [FIELD_W-1:0]   sel_q;
  logic [FIELD_W-1:0]   latch_n;

  curve25519_rr_pick u_pick (
    .valid      ({b_valid, a_valid}),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  assign sel_n = pick_grant[1] ? b_n : a_n;
  assign sel_q = pick_grant[1] ? b_q : a_q;

`ifdef CURVE25519_ARB_CLAMP_EN
  assign latch_n = clamp_scalar(sel_n);
`else
  assign latch_n = sel_n;
`endif

  assign wd_expired = (watchdog == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  // A busy core (e.g. after a timeout or reset) blocks new grants until it reports done
  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (core_done && pick_any) begin
          grant_en   = 1'b1;
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        core_start = 1'b1;
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (core_done || wd_expired) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign a_ready = grant_en & pick_grant[0];
  assign b_ready = grant_en & pick_grant[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_grant  <= ID_B;
      watchdog    <= '0;
      rsp_id      <= ID_A;
      rsp_timeout <= 1'b0;
      rsp_out     <= '0;
      core_n      <= '0;
      core_q      <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (grant_en) begin
            core_n     <= latch_n;
            core_q     <= sel_q;
            rsp_id     <= pick_grant[1] ? ID_B : ID_A;
            last_grant <= pick_grant[1] ? ID_B : ID_A;
          end
        end
        ST_SETTLE: begin
          watchdog <= '0;
        end
        // A completion in the same cycle as expiry is still reported as a good result
        ST_RUN: begin
          watchdog <= watchdog + TIMEOUT_W'(1);
          if (core_done) begin
            rsp_out     <= core_out;
            rsp_timeout <= 1'b0;
          end else if (wd_expired) begin
            rsp_out     <= '0;
            rsp_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
